uart_tx_fsm: RTL
================

UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, meaning clock cycles per serial bit period (legal range 1..65535).
REQ-002 Parameter STOP_BITS, default 1, meaning number of stop bit periods (legal values 1 or 2).
REQ-003 clk  input  1  single clock; all logic rising-edge triggered.
REQ-004 reset  input  1  synchronous, active-low reset (reset==0 sampled at posedge resets the block).
REQ-005 tx_data  input  8  byte to transmit; sampled only on an accepted handshake.
REQ-006 tx_valid  input  1  upstream asserts while tx_data holds a byte to send.
REQ-007 tx_ready  output  1  block can accept a byte this cycle.
REQ-008 txd  output  1  serial line, idle high; drives the downstream UART receiver's rx input.
REQ-009 tx_busy  output  1  high while a frame is in progress.
REQ-010 tx_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-012 Handshake: a byte is accepted in a cycle where tx_valid==1 and tx_ready==1; tx_ready SHALL equal (state==IDLE).
REQ-013 On acceptance, tx_data SHALL be latched into an internal 8-bit shift register; later tx_data changes have no effect on the frame.
REQ-014 txd SHALL go low (start bit) in the cycle after acceptance; state IDLE->START.
REQ-015 Each bit SHALL be held on txd for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads at every bit boundary.
REQ-016 DATA SHALL send 8 bits LSB first, tracked by a 3-bit index; DATA->PARITY (macro enabled) or DATA->STOP after index 7 completes.
REQ-017 STOP SHALL drive txd high for STOP_BITS bit periods, then return to IDLE.
REQ-018 Frame length SHALL be CLKS_PER_BIT*(1+8+P+STOP_BITS) cycles, P=1 with parity enabled else 0; defaults: 10 cycles.
REQ-019 tx_done SHALL pulse high for one cycle in the cycle after the last stop-bit cycle, coincident with tx_ready returning high.
REQ-020 tx_busy SHALL be high from the cycle after acceptance through the last stop-bit cycle, low otherwise.
REQ-021 Back-to-back: a byte offered while tx_done is high SHALL be accepted that cycle, giving exactly one idle-high cycle between consecutive frames.
REQ-022 In IDLE, txd SHALL remain high regardless of tx_data.
REQ-023 tx_valid deasserted in IDLE SHALL leave the block idle; no frame starts.
REQ-024 Unreachable state encodings SHALL recover to IDLE with txd high on the next cycle.

Reset
REQ-025 While reset==0: state=IDLE, txd=1, tx_ready=0, tx_busy=0, tx_done=0, counters and shift register cleared.
REQ-026 tx_ready SHALL become 1 in the first cycle after reset is sampled high.
REQ-027 Reset mid-frame SHALL abort the frame immediately: txd high from the next edge, no tx_done pulse, the byte discarded.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined: PARITY state present, sending one even-parity bit (XOR of the 8 data bits) for one bit period between DATA and STOP.
REQ-029 Macro UART_TX_PARITY_EN undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Verification
REQ-030 Defaults, no macro: accept 8'hA5 at cycle 0 -> txd cycles 1..10 = 0,1,0,1,0,0,1,0,1,1; tx_done=1 at cycle 11.
REQ-031 Back-to-back 8'h00 then 8'hFF with tx_valid held high -> second accept on the tx_done cycle; exactly one idle-high cycle between frames.
REQ-032 CLKS_PER_BIT=4, STOP_BITS=2, send 8'h01 -> start low 4 cycles, bit0 high 4 cycles, frame 44 cycles, tx_done at cycle 45.
REQ-033 UART_TX_PARITY_EN, send 8'h07 -> parity bit 1 after bit7; send 8'h03 -> parity bit 0; frame 11 cycles.
REQ-034 Reset asserted at cycle 5 of a frame -> txd=1 from next edge, tx_done never pulses, tx_ready=1 one cycle after reset releases.
REQ-035 Loopback: txd into the uart receiver, random bytes -> every received byte matches the sent byte, no error flag.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// UART transmitter: 8N1/8N2 framing (start, 8 data LSB first, optional
// even parity, 1-2 stop bits) with a valid/ready byte handshake.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit period (1..65535)
//   STOP_BITS     stop bit periods (1 or 2)
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset
//   tx_data   byte to send, sampled on an accepted handshake
//   tx_valid  upstream has a byte on tx_data
//   tx_ready  block can accept a byte this cycle (state == IDLE)
//   txd       serial line, idle high
//   tx_busy   frame in progress
//   tx_done   one-cycle pulse after the last stop-bit cycle
// Build option:
//   UART_TX_PARITY_EN  adds an even-parity bit between data and stop.

module uart_tx_fsm #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_e;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        stop_q, stop_d;
    logic        txd_q, txd_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        bit_end;
    logic        accept;

    assign bit_end = (cnt_q == 16'd0);
    assign accept  = ready_q & tx_valid;

    always_comb begin
        state_d = state_q;
        // Counter runs down and reloads at every bit boundary.
        cnt_d   = bit_end ? BIT_LAST : cnt_q - 16'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        stop_d  = stop_q;
        txd_d   = txd_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                cnt_d   = BIT_LAST;
                idx_d   = 3'd0;
                if (accept) begin
                    state_d = START;
                    shreg_d = tx_data;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = shreg_q[0];
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = ^shreg_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
                        stop_d  = STOP_LAST;
`endif
                    end else begin
                        // Shift register is left intact so parity
                        // can still be taken over the whole byte.
                        idx_d = idx_q + 3'd1;
                        txd_d = shreg_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    stop_d  = STOP_LAST;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_q) begin
                        stop_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                cnt_d   = BIT_LAST;
                idx_d   = 3'd0;
                stop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            stop_q  <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            stop_q  <= stop_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = ready_q;
    assign txd      = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
